// File: rtl/ads_pkg.sv
// Shared definitions for the ADS line packer: default geometry and FSM encoding.
package ads_pkg;

  localparam int ADS_CH_NUM = 64;
  localparam int ADS_DATA_W = 16;
  localparam int LINE_CNT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEND_A = 2'd1,
    ST_SEND_B = 2'd2
  } ads_state_e;

endpackage

// File: rtl/sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO; rd_data always shows the head entry.
module sync_fifo_fwft #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 16,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_wr;
  logic             do_rd;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_rd   = rd_en && !empty;
  // A full FIFO still takes a write when the head leaves in the same cycle.
  assign do_wr   = wr_en && (!full || do_rd);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= ptr_inc(wr_ptr);
      if (do_rd) rd_ptr <= ptr_inc(rd_ptr);
      case ({do_wr, do_rd})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ads_line_packer.sv
// Buffers ADS channel A/B samples and emits them as lines: CH_NUM A words then
// CH_NUM B words, with SOL/EOL markers, line counter and sticky overflow.
module ads_line_packer
  import ads_pkg::*;
#(
  parameter int CH_NUM = ADS_CH_NUM,
  parameter int DATA_W = ADS_DATA_W
) (
  input  logic                  CLK_100M,
  input  logic                  CLK_RST,
  input  logic                  ADS_INIT_OK,
  input  logic [DATA_W-1:0]     ADS_ADATA,
  input  logic                  ADS_AVLAID,
  input  logic [DATA_W-1:0]     ADS_BDATA,
  input  logic                  ADS_BVLAID,
  output logic [DATA_W-1:0]     PIX_DATA,
  output logic                  PIX_VALID,
  input  logic                  PIX_READY,
  output logic                  PIX_SOL,
  output logic                  PIX_EOL,
  output logic [LINE_CNT_W-1:0] LINE_CNT,
  output logic                  OVF,
  input  logic                  OVF_CLR
);

  localparam int WC_W  = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
  localparam int CNT_W = $clog2(CH_NUM + 1);

  ads_state_e            state;
  ads_state_e            state_nxt;
  logic [WC_W-1:0]       word_cnt;
  logic [LINE_CNT_W-1:0] line_cnt;
  logic                  ovf;

  logic              wr_a, wr_b, pop_a, pop_b, flush;
  logic              full_a, full_b, empty_a, empty_b;
  logic [DATA_W-1:0] head_a, head_b;
  logic [CNT_W-1:0]  cnt_a, cnt_b;
  logic              last_word, line_done, ovf_evt;

  assign flush = !ADS_INIT_OK;
  assign wr_a  = ADS_AVLAID && ADS_INIT_OK;
  assign wr_b  = ADS_BVLAID && ADS_INIT_OK;

  sync_fifo_fwft #(.DEPTH(CH_NUM), .WIDTH(DATA_W)) u_fifo_a (
    .clk     (CLK_100M),
    .rst_n   (CLK_RST),
    .flush   (flush),
    .wr_en   (wr_a),
    .wr_data (ADS_ADATA),
    .rd_en   (pop_a),
    .rd_data (head_a),
    .full    (full_a),
    .empty   (empty_a),
    .count   (cnt_a)
  );

  sync_fifo_fwft #(.DEPTH(CH_NUM), .WIDTH(DATA_W)) u_fifo_b (
    .clk     (CLK_100M),
    .rst_n   (CLK_RST),
    .flush   (flush),
    .wr_en   (wr_b),
    .wr_data (ADS_BDATA),
    .rd_en   (pop_b),
    .rd_data (head_b),
    .full    (full_b),
    .empty   (empty_b),
    .count   (cnt_b)
  );

  assign last_word = (word_cnt == WC_W'(CH_NUM - 1));

  always_comb begin
    state_nxt = state;
    PIX_VALID = 1'b0;
    PIX_DATA  = '0;
    PIX_SOL   = 1'b0;
    PIX_EOL   = 1'b0;
    pop_a     = 1'b0;
    pop_b     = 1'b0;
    line_done = 1'b0;
    case (state)
      ST_IDLE: begin
        if (ADS_INIT_OK) state_nxt = ST_SEND_A;
      end
      ST_SEND_A: begin
        PIX_VALID = !empty_a;
        PIX_DATA  = empty_a ? '0 : head_a;
        PIX_SOL   = !empty_a && (word_cnt == '0);
        pop_a     = !empty_a && PIX_READY;
        if (pop_a && last_word) state_nxt = ST_SEND_B;
      end
      ST_SEND_B: begin
        PIX_VALID = !empty_b;
        PIX_DATA  = empty_b ? '0 : head_b;
        PIX_EOL   = !empty_b && last_word;
        pop_b     = !empty_b && PIX_READY;
        if (pop_b && last_word) begin
          state_nxt = ST_SEND_A;
          line_done = ADS_INIT_OK;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    // Losing the ADS configuration abandons whatever line was in flight.
    if (!ADS_INIT_OK) state_nxt = ST_IDLE;
  end

  // A sample is lost only when its FIFO is full and nothing leaves it this cycle.
  assign ovf_evt = (wr_a && full_a && !pop_a) || (wr_b && full_b && !pop_b);

  always_ff @(posedge CLK_100M or negedge CLK_RST) begin
    if (!CLK_RST) begin
      state    <= ST_IDLE;
      word_cnt <= '0;
      line_cnt <= '0;
      ovf      <= 1'b0;
    end else begin
      state <= state_nxt;
      if (!ADS_INIT_OK)
        word_cnt <= '0;
      else if (pop_a || pop_b)
        word_cnt <= last_word ? '0 : word_cnt + WC_W'(1);
      if (line_done) line_cnt <= line_cnt + LINE_CNT_W'(1);
      if (ovf_evt)      ovf <= 1'b1;
      else if (OVF_CLR) ovf <= 1'b0;
    end
  end

  assign LINE_CNT = line_cnt;
  assign OVF      = ovf;

  a_fifo_bound: assert property (@(posedge CLK_100M) disable iff (!CLK_RST)
    (cnt_a <= CNT_W'(CH_NUM)) && (cnt_b <= CNT_W'(CH_NUM)));

endmodule

// File: doc/ads_line_packer.md
ADS_LINE_PACKER -- requirements
Module: ads_line_packer

Interface
REQ-001 The block SHALL have parameter CH_NUM, default 64, meaning samples per ADS channel per line.
REQ-002 The block SHALL have parameter DATA_W, default 16, meaning the sample width.
REQ-003 The block SHALL have the port CLK_100M  in  1  sole clock; all logic is rising-edge.
REQ-004 The block SHALL have the port CLK_RST  in  1  reset, asynchronous, active-low.
REQ-005 The block SHALL have the port ADS_INIT_OK  in  1  ADS configured; samples ignored while low.
REQ-006 The block SHALL have the ports ADS_ADATA / ADS_BDATA  in  DATA_W  channel A / B sample.
REQ-007 The block SHALL have the ports ADS_AVLAID / ADS_BVLAID  in  1  single-cycle strobe qualifying ADS_ADATA / ADS_BDATA.
REQ-008 The block SHALL have the ports PIX_DATA  out  DATA_W  and PIX_VALID  out  1  output stream data and valid.
REQ-009 The block SHALL have the port PIX_READY  in  1  downstream accept.
REQ-010 The block SHALL have the ports PIX_SOL / PIX_EOL  out  1  first / last word of a line, qualified by PIX_VALID.
REQ-011 The block SHALL have the port LINE_CNT  out  16  completed-line count.
REQ-012 The block SHALL have the ports OVF  out  1  sticky overflow flag, and OVF_CLR  in  1  clears OVF.

Function
REQ-013 The block SHALL write each ADS_ADATA with ADS_AVLAID=1 and ADS_INIT_OK=1 into FIFO_A (depth CH_NUM) in the same cycle.
REQ-014 The block SHALL write each ADS_BDATA with ADS_BVLAID=1 and ADS_INIT_OK=1 into FIFO_B (depth CH_NUM) in the same cycle.
REQ-015 The block SHALL accept simultaneous A and B strobes in one cycle, each into its own FIFO.
REQ-016 The block SHALL drop a strobed sample whose FIFO is full, set OVF the next cycle, and leave FIFO contents unchanged.
REQ-017 The block SHALL keep OVF set until OVF_CLR=1; if clear and a new overflow coincide, OVF SHALL stay 1.
REQ-018 The FSM SHALL have states IDLE, SEND_A and SEND_B; IDLE moves to SEND_A when ADS_INIT_OK=1.
REQ-019 In SEND_A: PIX_VALID = FIFO_A not empty; PIX_DATA = FIFO_A head (first-word fall-through); a pop occurs on PIX_VALID&PIX_READY.
REQ-020 SEND_B SHALL behave as SEND_A using FIFO_B.
REQ-021 A word counter SHALL count pops 0..CH_NUM-1 per state; after the CH_NUM-th pop the FSM SHALL move SEND_A->SEND_B and SEND_B->SEND_A, and the counter SHALL clear.
REQ-022 PIX_SOL SHALL be 1 for word 0 of SEND_A; PIX_EOL SHALL be 1 for word CH_NUM-1 of SEND_B.
REQ-023 LINE_CNT SHALL increment on the SEND_B->SEND_A transition and wrap 0xFFFF->0x0000.
REQ-024 A sample written at cycle N with the FSM in the matching state and the FIFO previously empty SHALL give PIX_VALID=1 at N+1.
REQ-025 PIX_DATA, PIX_SOL and PIX_EOL SHALL hold stable while PIX_VALID=1 and PIX_READY=0.
REQ-026 A FIFO SHALL support a write and a pop in the same cycle when full, with the count unchanged and no overflow.
REQ-027 When ADS_INIT_OK falls, the FSM SHALL return to IDLE, the FIFOs and word counter SHALL flush, and LINE_CNT and OVF SHALL be retained.

Reset
REQ-028 Reset SHALL asynchronously force: FSM=IDLE, FIFOs empty, word counter 0, PIX_VALID=0, PIX_SOL=0, PIX_EOL=0, PIX_DATA=0, LINE_CNT=0, OVF=0.
REQ-029 Reset mid-line SHALL discard the partial line; the first line after reset SHALL start at word 0 of SEND_A.

Structure
REQ-030 The FSM state encoding, CH_NUM and DATA_W defaults SHALL reside in a shared package ads_pkg.
REQ-031 The FIFO SHALL be one sub-module, sync_fifo_fwft (parameters DEPTH, WIDTH; full, empty and count outputs), instantiated twice.

Verification
REQ-032 The bench SHALL cover: with ADS_INIT_OK=1 and PIX_READY=1, 64 A samples 0x0000..0x003F then 64 B samples 0x1000..0x103F -> 128 words in order, SOL on 0x0000, EOL on 0x103F, LINE_CNT=1.
REQ-033 The bench SHALL cover: A and B strobed together for 64 cycles with PIX_READY=1 -> all A words are emitted before any B word, and OVF=0.
REQ-034 The bench SHALL cover: PIX_READY=0, 65 A samples -> OVF=1, sample 65 absent, and the first 64 samples emitted once PIX_READY=1; OVF_CLR -> OVF=0.
REQ-035 The bench SHALL cover: PIX_READY toggled randomly for 3 lines -> no word lost or duplicated, data stable during stalls, and LINE_CNT=3.
REQ-036 The bench SHALL cover: async reset asserted after 30 A words -> outputs zero immediately, and the next line starts with SOL on a fresh word.
REQ-037 The bench SHALL cover: ADS_INIT_OK=0 with strobes -> no writes and PIX_VALID=0; LINE_CNT preset to 0xFFFF via 65535 lines plus one more line -> LINE_CNT=0x0000.
